// File: rtl/seq_detect_pkg.sv
// Shared state encodings for the scan arbiter controller and the "1011" detector.
package seq_detect_pkg;

  typedef enum logic [2:0] {
    DET_IDLE,
    DET_S1,
    DET_S10,
    DET_S101,
    DET_S1011
  } det_state_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SHIFT,
    ST_DONE
  } ctl_state_e;

  // Overlapping "1011" transition table; S1011 behaves like S1 for the next bit.
  function automatic det_state_e det_next(input det_state_e s, input logic b);
    det_state_e n;
    n = DET_IDLE;
    case (s)
      DET_IDLE:  n = b ? DET_S1    : DET_IDLE;
      DET_S1:    n = b ? DET_S1    : DET_S10;
      DET_S10:   n = b ? DET_S101  : DET_IDLE;
      DET_S101:  n = b ? DET_S1011 : DET_IDLE;
      DET_S1011: n = b ? DET_S1    : DET_S10;
      default:   n = DET_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_match_fsm.sv
// Serial "1011" detector; match pulses on the bit that enters S1011.
module seq_match_fsm
  import seq_detect_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic bit_in,
  input  logic bit_vld,
  output logic match
);

  det_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    match   = 1'b0;
    if (clear) begin
      state_d = DET_IDLE;
    end else if (bit_vld) begin
      state_d = det_next(state_q, bit_in);
      match   = (state_d == DET_S1011);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= DET_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter granting one requester at a time a WORD_W-cycle serial
// scan of its word for overlapping "1011" patterns.
module seq_scan_arbiter
  import seq_detect_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*WORD_W-1:0]    word,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_REQ)-1:0]   done_id,
  output logic [$clog2(WORD_W+1)-1:0]  match_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WORD_W+1);
  localparam int BIT_W = $clog2(WORD_W);

  ctl_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [IDX_W-1:0]   done_id_q, done_id_d;

  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic [WORD_W-1:0]  pick_word;
  logic               det_clear, det_vld, det_match;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    pick_idx = '0;
    cand     = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_gnt_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    pick_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_word = word[i*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    win_d       = win_q;
    shreg_d     = shreg_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    match_cnt_d = match_cnt_q;
    done_id_d   = done_id_q;
    det_clear   = 1'b0;
    det_vld     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d    = ST_GRANT;
          win_d      = pick_idx;
          last_gnt_d = pick_idx;
          shreg_d    = pick_word;
        end
      end
      ST_GRANT: begin
        state_d   = ST_SHIFT;
        bit_d     = '0;
        cnt_d     = '0;
        det_clear = 1'b1;
      end
      ST_SHIFT: begin
        det_vld = 1'b1;
        shreg_d = shreg_q << 1;
        bit_d   = bit_q + 1'b1;
        cnt_d   = cnt_q + CNT_W'(det_match);
        // Last bit's match must be folded into the reported count.
        if (bit_q == BIT_W'(WORD_W-1)) begin
          state_d     = ST_DONE;
          match_cnt_d = cnt_q + CNT_W'(det_match);
          done_id_d   = win_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= IDX_W'(NUM_REQ-1);
      win_q       <= '0;
      shreg_q     <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      match_cnt_q <= '0;
      done_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      win_q       <= win_d;
      shreg_q     <= shreg_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      match_cnt_q <= match_cnt_d;
      done_id_q   <= done_id_d;
    end
  end

  seq_match_fsm u_det (
    .clk     (clk),
    .reset   (reset),
    .clear   (det_clear),
    .bit_in  (shreg_q[WORD_W-1]),
    .bit_vld (det_vld),
    .match   (det_match)
  );

  assign gnt       = (state_q == ST_GRANT) ? (NUM_REQ'(1) << win_q) : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: doc/seq_scan_arbiter.md
SEQ_SCAN_ARBITER -- requirements
Module: seq_scan_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing the detector; legal range 2..8.
REQ-002 Parameter WORD_W, default 8, SHALL set the word width scanned per grant; legal range 4..32.
REQ-003 clk  input  1  SHALL be the clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 req  input  NUM_REQ  SHALL carry one scan request bit per requester.
REQ-006 word  input  NUM_REQ*WORD_W  SHALL carry one flat word per requester; requester i occupies bits [i*WORD_W +: WORD_W].
REQ-007 gnt  output  NUM_REQ  SHALL be a one-hot, one-cycle grant pulse.
REQ-008 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-010 done_id  output  $clog2(NUM_REQ)  SHALL give the index of the requester whose result is reported.
REQ-011 match_cnt  output  $clog2(WORD_W+1)  SHALL give the number of overlapping "1011" occurrences found in the scanned word.

Function
REQ-012 Controller FSM SHALL have four states: IDLE, GRANT, SHIFT, DONE.
REQ-013 IDLE transitions: req != 0 at a clock edge -> GRANT; otherwise remain in IDLE; req SHALL be ignored in every other state.
REQ-014 On IDLE->GRANT the arbiter SHALL pick the winner round-robin, searching from last_gnt+1 with wrap-around, and SHALL latch that requester's word.
REQ-015 GRANT SHALL last exactly one cycle with gnt[winner]=1, then go to SHIFT; requesters SHALL hold word until they see gnt, and deassert req afterwards.
REQ-016 SHIFT SHALL last exactly WORD_W cycles, feeding one latched bit per cycle to the detector, MSB first, then go to DONE.
REQ-017 Detector SHALL be cleared to its idle state on entry to SHIFT; matches SHALL NOT span two words.
REQ-018 Detector transitions: IDLE 1->S1, 0->IDLE; S1 1->S1, 0->S10; S10 1->S101, 0->IDLE; S101 1->S1011, 0->IDLE; S1011 1->S1, 0->S10 (overlapping detection).
REQ-019 Each SHIFT cycle whose bit moves the detector into S1011 SHALL increment an internal counter, which is cleared on entry to SHIFT; the counter SHALL never wrap (maximum count is floor((WORD_W-1)/3)).
REQ-020 DONE SHALL last one cycle with done=1 and then return to IDLE; done_id and match_cnt SHALL be registered on entry to DONE and held until the next DONE.
REQ-021 Throughput SHALL be one word per WORD_W+3 cycles: IDLE sample, GRANT, WORD_W SHIFT cycles, DONE.
REQ-022 A req that drops before it is sampled in IDLE SHALL produce no grant; a req still high after its own DONE SHALL be treated as a new request.

Reset
REQ-023 Reset SHALL force: FSM=IDLE, gnt=0, busy=0, done=0, done_id=0, match_cnt=0, internal counter=0, detector=IDLE, last_gnt=NUM_REQ-1 (so requester 0 has first priority).
REQ-024 Reset asserted mid-SHIFT or mid-GRANT SHALL abort the scan with no done pulse; reset SHALL take priority over every other event.

Structure
REQ-025 Package seq_detect_pkg SHALL hold the detector state encodings (IDLE, S1, S10, S101, S1011) and the controller state encodings.
REQ-026 The detector SHALL be a sub-module seq_match_fsm with ports clk, reset, clear, bit_in, bit_vld, match (match pulses on entry to S1011).

Verification
REQ-027 Single requester: WORD_W=8, req=0001, word0=8'b1011_0110 -> gnt=0001 one cycle, done after 8 SHIFT cycles, done_id=0, match_cnt=2.
REQ-028 No match and all-ones: word=8'h00 -> match_cnt=0; word=8'hFF -> match_cnt=0.
REQ-029 Contention: req=1111 held continuously from reset -> grants in order 0,1,2,3,0, each exactly 11 cycles apart.
REQ-030 Cross-word isolation: word A=8'b0000_0101 then word B=8'b1000_0000 from the same requester -> match_cnt=0 for both.
REQ-031 Reset at the 4th SHIFT cycle -> no done pulse; busy=0 the next cycle; next req=0010 is granted to requester 1 with round-robin state reset.
REQ-032 Late request: req1 rises during SHIFT for requester 0 -> requester 1 is granted only after requester 0's DONE, never before.
